// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the instruction-memory path.
// The processor top reuses the address/data widths from here.
package imem_pkg;

   localparam int IMEM_ADDR_W = 12;
   localparam int IMEM_DATA_W = 16;
   localparam int IMEM_DEPTH  = 4096;
   localparam int IMEM_LEN_W  = 16;

   typedef enum logic [2:0] {
      S_LEN_HI,
      S_LEN_LO,
      S_DATA_HI,
      S_DATA_LO,
      S_WRITE,
      S_CHECK,
      S_DONE,
      S_ERROR
   } imem_state_t;

   // States in which the loader takes a byte from the stream.
   function automatic logic state_takes_byte(input imem_state_t s);
      return (s == S_LEN_HI) || (s == S_LEN_LO) || (s == S_DATA_HI) ||
             (s == S_DATA_LO) || (s == S_CHECK);
   endfunction

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles 16-bit words, writes them to instruction
// memory from address 0, verifies an XOR checksum and then releases the CPU.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_LEN_HI  | waiting for word-count high byte
// S_LEN_LO  | waiting for word-count low byte; range check on count
// S_DATA_HI | waiting for instruction MSB byte
// S_DATA_LO | waiting for instruction LSB byte
// S_WRITE   | one-cycle memory write strobe, stream stalled
// S_CHECK   | waiting for checksum byte
// S_DONE    | image verified; CPU released one cycle after entry
// S_ERROR   | oversize count or checksum mismatch; CPU held in reset
module imem_loader
   import imem_pkg::*;
#(
   parameter int ADDR_W = IMEM_ADDR_W,
   parameter int DATA_W = IMEM_DATA_W,
   parameter int DEPTH  = IMEM_DEPTH
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_wren,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data,
   output logic              cpu_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   words_loaded
);

   localparam logic [IMEM_LEN_W:0] L_DEPTH = (IMEM_LEN_W + 1)'(DEPTH);

   imem_state_t               r_state;
   imem_state_t               w_next;
   logic [IMEM_LEN_W-1:0]     r_len;
   logic [7:0]                r_hi;
   logic [7:0]                r_csum;
   logic [DATA_W-1:0]         r_mem_data;
   logic [ADDR_W:0]           r_words;
   logic                      r_ready;
   logic                      r_cpu_reset;

   logic                      w_xfer;
   logic [IMEM_LEN_W-1:0]     w_len_full;
   logic [ADDR_W:0]           w_words_inc;
   logic                      w_last_word;

   assign w_xfer      = byte_valid & r_ready;
   assign w_len_full  = {r_len[IMEM_LEN_W-1:8], byte_data};
   assign w_words_inc = r_words + 1'b1;
   assign w_last_word = (IMEM_LEN_W'(w_words_inc) == r_len);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_LEN_HI: begin
            if (w_xfer) w_next = S_LEN_LO;
         end
         S_LEN_LO: begin
            if (w_xfer) begin
               if ({1'b0, w_len_full} > L_DEPTH) w_next = S_ERROR;
               else if (w_len_full == '0)        w_next = S_CHECK;
               else                              w_next = S_DATA_HI;
            end
         end
         S_DATA_HI: begin
            if (w_xfer) w_next = S_DATA_LO;
         end
         S_DATA_LO: begin
            if (w_xfer) w_next = S_WRITE;
         end
         S_WRITE: begin
            w_next = w_last_word ? S_CHECK : S_DATA_HI;
         end
         S_CHECK: begin
            if (w_xfer) w_next = (byte_data == r_csum) ? S_DONE : S_ERROR;
         end
         S_DONE, S_ERROR: begin
            if (start) w_next = S_LEN_HI;
         end
         default: w_next = S_LEN_HI;
      endcase
   end

   // Ready is registered from the next state so it never depends on byte_valid
   // within a cycle, and it reads low for the first cycle out of reset.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state     <= S_LEN_HI;
         r_len       <= '0;
         r_hi        <= '0;
         r_csum      <= '0;
         r_mem_data  <= '0;
         r_words     <= '0;
         r_ready     <= 1'b0;
         r_cpu_reset <= 1'b1;
      end else begin
         r_state     <= w_next;
         r_ready     <= state_takes_byte(w_next);
         r_cpu_reset <= !((r_state == S_DONE) && !start);
         case (r_state)
            S_LEN_HI: begin
               if (w_xfer) r_len[IMEM_LEN_W-1:8] <= byte_data;
            end
            S_LEN_LO: begin
               if (w_xfer) r_len[7:0] <= byte_data;
            end
            S_DATA_HI: begin
               if (w_xfer) begin
                  r_hi   <= byte_data;
                  r_csum <= r_csum ^ byte_data;
               end
            end
            S_DATA_LO: begin
               if (w_xfer) begin
                  r_mem_data <= {r_hi, byte_data};
                  r_csum     <= r_csum ^ byte_data;
               end
            end
            S_WRITE: begin
               r_words <= w_words_inc;
            end
            S_DONE, S_ERROR: begin
               if (start) begin
                  r_words <= '0;
                  r_csum  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign byte_ready   = r_ready;
   assign mem_wren     = (r_state == S_WRITE);
   assign mem_address  = r_words[ADDR_W-1:0];
   assign mem_data     = r_mem_data;
   assign cpu_reset    = r_cpu_reset;
   assign done         = (r_state == S_DONE);
   assign error        = (r_state == S_ERROR);
   assign words_loaded = r_words;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the processor's instruction-memory port. It receives a program as a byte stream over a valid/ready handshake and assembles 16-bit instruction words. It writes those words to sequential 12-bit instruction-memory addresses starting at 0. It holds the processor in reset until a complete, checksum-verified image has been written, then releases it.

Parameters:
ADDR_W, 12, instruction-memory address width (matches processor PC width)
DATA_W, 16, instruction width; fixed at 2 bytes per word
DEPTH, 4096, maximum words accepted (2**ADDR_W)

Ports:
CLOCK_50  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high; clock CLOCK_50
start  input  1  one-cycle pulse; begins a new load from DONE or ERROR
byte_valid  input  1  source has a byte on byte_data
byte_data  input  8  stream byte
byte_ready  output  1  loader accepts byte this cycle (transfer = valid & ready)
mem_wren  output  1  one-cycle write strobe to instruction memory
mem_address  output  ADDR_W  write address
mem_data  output  DATA_W  write data
cpu_reset  output  1  high = processor held in reset
done  output  1  image loaded and verified (level)
error  output  1  load failed (level)
words_loaded  output  ADDR_W+1  count of words written in current load

Behaviour:
- Stream format: LEN_HI, LEN_LO (word count N, big-endian), then N words (each MSB byte first), then one checksum byte.
- Checksum: XOR of all bytes following LEN_LO, excluding the checksum byte itself.
- Reset values: byte_ready=0, mem_wren=0, mem_address=0, mem_data=0, cpu_reset=1, done=0, error=0, words_loaded=0, state=LEN_HI, len=0, csum=0.
- Reset wins over every other input in the same cycle. Reset mid-load aborts the load; memory contents already written are left as they are.
- State LEN_HI: byte_ready=1; on transfer, len[15:8] <= byte.
- State LEN_LO: byte_ready=1; on transfer, len[7:0] <= byte. Then:
  - len > DEPTH -> ERROR.
  - len == 0 -> CHECK.
  - otherwise -> DATA_HI.
- State DATA_HI: byte_ready=1; on transfer, hi <= byte, csum ^= byte -> DATA_LO.
- State DATA_LO: byte_ready=1; on transfer, mem_data <= {hi, byte}, csum ^= byte -> WRITE.
- State WRITE: byte_ready=0; mem_wren=1 for exactly this cycle, with mem_address = words_loaded[ADDR_W-1:0]. Next cycle: words_loaded += 1, mem_address advances. If words_loaded+1 == len -> CHECK, else -> DATA_HI.
- Throughput: at most one word per 3 cycles.
- State CHECK: byte_ready=1; on transfer, compare byte to csum. Match -> DONE; mismatch -> ERROR.
- State DONE: done=1, cpu_reset=0 (registered, asserted low the cycle after entry), byte_ready=0.
- State ERROR: error=1, cpu_reset=1, byte_ready=0.
- start in DONE or ERROR:
  - clears done, error, words_loaded, csum and mem_address;
  - sets cpu_reset=1 on the next edge;
  - goes to LEN_HI.
- start in any other state is ignored.
- byte_valid without byte_ready: no state change. Data must be held by the source (standard valid/ready; byte_ready never depends combinationally on byte_valid).
- Address wrap cannot occur: len <= DEPTH bounds the last address to DEPTH-1. len == DEPTH is legal.
- mem_wren is never asserted outside WRITE.

Decomposition:
- Shared package imem_pkg:
  - state enum (S_LEN_HI, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_WRITE, S_CHECK, S_DONE, S_ERROR);
  - IMEM_ADDR_W=12, IMEM_DATA_W=16, IMEM_DEPTH=4096, reused by the processor top.
- Single module; no sub-module. The checksum is one XOR register, which does not justify a separate block.

Test Plan:
- Nominal: stream 00 02 | 12 34 | AB CD | chk=0x12^0x34^0xAB^0xCD=0x40 -> two mem_wren pulses: addr 0 data 0x1234, addr 1 data 0xABCD. Then done=1, cpu_reset=0, words_loaded=2.
- Bad checksum: same stream with chk=0x41 -> both words written, then error=1, cpu_reset stays 1, done=0.
- Zero length: 00 00 00 -> no mem_wren, done=1, cpu_reset=0.
- Oversize: 10 01 (4097) -> ERROR immediately after LEN_LO, no mem_wren, byte_ready=0.
- Backpressure/gaps: byte_valid toggled randomly during nominal stream -> identical writes. byte_ready is 0 in every WRITE cycle, and no byte is lost or duplicated.
- Reset mid-load after 1 word, then start-after-DONE reload of 1 word 0xBEEF (chk 0x51):
  - reset -> all outputs at reset values;
  - reload -> write addr 0 data 0xBEEF, cpu_reset high from the cycle after start until DONE.
